// File: rtl/twiddle_gen_if.sv
// Request/stream bundle for twiddle_gen: start/stage in, twiddle words out under valid/ready.
// The optional inv input (macro TWIDDLE_GEN_CONJ_EN) is a plain port on twiddle_gen itself.
interface twiddle_gen_if #(
  parameter int DATA_WIDTH = 16,
  parameter int LOG2_N     = 10
) ();
  localparam int SW = $clog2(LOG2_N / 2);

  logic                  start;
  logic [SW-1:0]         stage;
  logic                  ready;
  logic                  valid;
  logic [DATA_WIDTH-1:0] datar;
  logic [DATA_WIDTH-1:0] datai;
  logic                  last;
  logic                  busy;

  modport master (output start, stage, ready, input valid, datar, datai, last, busy);
  modport slave  (input start, stage, ready, output valid, datar, datai, last, busy);
endinterface

// File: rtl/twiddle_gen.sv
// Radix-4 FFT twiddle generator: streams N twiddles per stage from a quarter-wave cosine ROM.
// Optional feature: define TWIDDLE_GEN_CONJ_EN to add the inv port (conjugate twiddles).
module twiddle_gen #(
  parameter int DATA_WIDTH = 16,
  parameter int LOG2_N     = 10
) (
  input  logic clk,
  input  logic rst,
`ifdef TWIDDLE_GEN_CONJ_EN
  input  logic inv,
`endif
  twiddle_gen_if.slave bus
);
  localparam int N      = 1 << LOG2_N;
  localparam int QN     = N / 4;
  localparam int QW     = LOG2_N - 2;
  localparam int NSTAGE = LOG2_N / 2;
  localparam int SW     = $clog2(NSTAGE);
  localparam logic [SW:0] NSTAGE_W = (SW + 1)'(NSTAGE);

  typedef enum logic [0:0] {IDLE = 1'b0, RUN = 1'b1} state_t;

  function automatic logic [DATA_WIDTH-1:0] cos_entry(input int i);
    real x;
    x = $cos(2.0 * 3.14159265358979323846 * real'(i) / real'(N))
        * real'((64'd1 << (DATA_WIDTH - 1)) - 64'd1);
    cos_entry = DATA_WIDTH'($rtoi(x + 0.5));
  endfunction

  // Quarter-wave table holds QN+1 points so both C[r] and C[QN-r] are direct lookups.
  logic [DATA_WIDTH-1:0] rom_s [0:QN];
  for (genvar g = 0; g <= QN; g++) begin : g_rom
    localparam logic [DATA_WIDTH-1:0] CV = cos_entry(g);
    assign rom_s[g] = CV;
  end

  state_t                state_r, state_s;
  logic                  busy_r, issuing_r;
  logic [QW-1:0]         b_r;
  logic [1:0]            m_r;
  logic [SW-1:0]         stage_r;
  logic                  s1_valid_r, s1_last_r;
  logic [1:0]            q_r;
  logic [QW-1:0]         r_r;
  logic                  valid_r, last_r;
  logic [DATA_WIDTH-1:0] datar_r, datai_r;

  logic                  adv_s, start_ok_s, issue_s, last_issue_s, done_s;
  logic [QW-1:0]         j_s;
  logic [LOG2_N-1:0]     k_s;
  logic [QW:0]           addr_a_s, addr_b_s;
  logic [DATA_WIDTH-1:0] ca_s, cb_s, re_s, im_fwd_s, im_s;

  // A stalled output word freezes every stage behind it.
  assign adv_s        = !valid_r || bus.ready;
  assign start_ok_s   = bus.start && (state_r == IDLE) && ({1'b0, bus.stage} < NSTAGE_W);
  assign issue_s      = issuing_r && adv_s;
  assign last_issue_s = (b_r == QW'(QN - 1)) && (m_r == 2'd3);
  assign done_s       = valid_r && bus.ready && last_r;
  assign j_s          = b_r << {stage_r, 1'b0};
  assign k_s          = {{(LOG2_N - 2){1'b0}}, m_r} * {2'b00, j_s};
  assign addr_a_s     = {1'b0, r_r};
  assign addr_b_s     = (QW + 1)'(QN) - addr_a_s;
  assign ca_s         = rom_s[addr_a_s];
  assign cb_s         = rom_s[addr_b_s];

  // Next-state: run from an accepted start until the final word is taken.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (start_ok_s) state_s = RUN;
        else            state_s = IDLE;
      end
      RUN: begin
        if (done_s) state_s = IDLE;
        else        state_s = RUN;
      end
      default: state_s = IDLE;
    endcase
  end

  // Quadrant fold: rebuild (cos, -sin) from the quarter-wave samples.
  always_comb begin
    re_s     = '0;
    im_fwd_s = '0;
    case (q_r)
      2'd0:    begin re_s = ca_s;  im_fwd_s = -cb_s; end
      2'd1:    begin re_s = -cb_s; im_fwd_s = -ca_s; end
      2'd2:    begin re_s = -ca_s; im_fwd_s = cb_s;  end
      default: begin re_s = '0;    im_fwd_s = '0;    end
    endcase
  end

`ifdef TWIDDLE_GEN_CONJ_EN
  logic inv_r;

  // Conjugate request is latched with the start that launches the stage.
  always_ff @(posedge clk) begin
    if (rst)             inv_r <= 1'b0;
    else if (start_ok_s) inv_r <= inv;
    else                 inv_r <= inv_r;
  end

  // Negate the imaginary part for inverse-FFT sequences.
  always_comb begin
    im_s = im_fwd_s;
    if (inv_r) im_s = -im_fwd_s;
    else       im_s = im_fwd_s;
  end
`else
  assign im_s = im_fwd_s;
`endif

  // Counters, index stage and registered table read.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= IDLE;
      busy_r     <= 1'b0;
      issuing_r  <= 1'b0;
      b_r        <= '0;
      m_r        <= 2'd0;
      stage_r    <= '0;
      s1_valid_r <= 1'b0;
      s1_last_r  <= 1'b0;
      q_r        <= 2'd0;
      r_r        <= '0;
      valid_r    <= 1'b0;
      last_r     <= 1'b0;
      datar_r    <= '0;
      datai_r    <= '0;
    end else begin
      state_r <= state_s;
      busy_r  <= (state_s == RUN);
      if (start_ok_s) begin
        stage_r   <= bus.stage;
        issuing_r <= 1'b1;
        b_r       <= '0;
        m_r       <= 2'd0;
      end else if (issue_s) begin
        m_r <= m_r + 2'd1;
        if (m_r == 2'd3) b_r <= b_r + QW'(1);
        if (last_issue_s) issuing_r <= 1'b0;
      end
      if (adv_s) begin
        s1_valid_r <= issue_s;
        s1_last_r  <= issue_s && last_issue_s;
        q_r        <= k_s[LOG2_N-1 -: 2];
        r_r        <= k_s[QW-1:0];
        valid_r    <= s1_valid_r;
        last_r     <= s1_last_r;
        if (s1_valid_r) begin
          datar_r <= re_s;
          datai_r <= im_s;
        end
      end
    end
  end

  assign bus.valid = valid_r;
  assign bus.last  = last_r;
  assign bus.busy  = busy_r;
  assign bus.datar = datar_r;
  assign bus.datai = datai_r;
endmodule

// File: tb/tb_twiddle_gen.sv
// Self-checking bench for twiddle_gen (N=1024, 16-bit) against a trig reference model.
// Define TWIDDLE_GEN_CONJ_EN to also exercise the conjugate (inv) path.
module tb_twiddle_gen;
  localparam real PI = 3.14159265358979323846;

  logic clk = 1'b0;
  logic rst;
`ifdef TWIDDLE_GEN_CONJ_EN
  logic inv;
`endif

  twiddle_gen_if #(.DATA_WIDTH(16), .LOG2_N(10)) bif ();

  twiddle_gen #(.DATA_WIDTH(16), .LOG2_N(10)) dut (
    .clk(clk),
    .rst(rst),
`ifdef TWIDDLE_GEN_CONJ_EN
    .inv(inv),
`endif
    .bus(bif.slave)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int got_re[$];
  int got_im[$];
  int ref_re[$];
  int ref_im[$];
  bit timed_out;
  int first_cyc, last_cyc, hold_viol;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int rnd(input real x);
    if (x >= 0.0) return $rtoi(x + 0.5);
    return -$rtoi(-x + 0.5);
  endfunction

  // Reference: twiddle for word idx of a stage, straight from W_N^k = cos - j*sin.
  function automatic void model_word(input int stg, input int idx, input bit conj,
                                     output int re, output int im);
    int b, m, j, k;
    real a;
    b  = idx / 4;
    m  = idx % 4;
    j  = (b * (1 << (2 * stg))) % 256;
    k  = m * j;
    a  = 2.0 * PI * real'(k) / 1024.0;
    re = rnd($cos(a) * 32767.0);
    im = rnd(-$sin(a) * 32767.0);
    if (conj) im = -im;
  endfunction

  function automatic int count_mismatch(input int stg, input bit conj);
    int re, im, n;
    n = 0;
    for (int i = 0; i < got_re.size(); i++) begin
      model_word(stg, i, conj, re, im);
      if (got_re[i] != re || got_im[i] != im) n++;
    end
    return n;
  endfunction

  function automatic int gre(input int i);
    if (i < got_re.size()) return got_re[i];
    return -99999;
  endfunction

  function automatic int gim(input int i);
    if (i < got_im.size()) return got_im[i];
    return -99999;
  endfunction

  task automatic do_start(input int stg);
    bif.start = 1'b1;
    bif.stage = 3'(stg);
    step();
    bif.start = 1'b0;
  endtask

  // Accept words with random ready until last, max_words, or the cycle budget.
  task automatic collect(input int pct, input int max_words, input int budget,
                         input int poke_at, input int poke_stage);
    int cyc, s_re, s_im;
    bit done, poked, stall, s_last;
    got_re.delete();
    got_im.delete();
    timed_out = 1'b0;
    first_cyc = -1;
    last_cyc  = -1;
    hold_viol = 0;
    done = 1'b0; poked = 1'b0; stall = 1'b0; s_last = 1'b0;
    cyc = 0; s_re = 0; s_im = 0;
    while (!done && cyc < budget) begin
      if (stall && (bif.valid !== 1'b1 || int'($signed(bif.datar)) != s_re ||
                    int'($signed(bif.datai)) != s_im || bif.last !== s_last))
        hold_viol++;
      bif.ready = (int'($urandom_range(99)) < pct);
      stall  = bif.valid && !bif.ready;
      s_re   = int'($signed(bif.datar));
      s_im   = int'($signed(bif.datai));
      s_last = bif.last;
      if (bif.valid && bif.ready) begin
        got_re.push_back(int'($signed(bif.datar)));
        got_im.push_back(int'($signed(bif.datai)));
        if (first_cyc < 0) first_cyc = cyc;
        if (bif.last || got_re.size() >= max_words) begin
          done = 1'b1;
          last_cyc = cyc;
        end
      end
      if (!poked && poke_at >= 0 && got_re.size() >= poke_at) begin
        bif.start = 1'b1;
        bif.stage = 3'(poke_stage);
        poked = 1'b1;
      end else begin
        bif.start = 1'b0;
      end
      step();
      cyc++;
    end
    bif.start = 1'b0;
    timed_out = !done;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bif.start = 1'b1;
    bif.stage = 3'd0;
    bif.ready = 1'b1;
`ifdef TWIDDLE_GEN_CONJ_EN
    inv = 1'b0;
`endif
    repeat (3) step();
    checks++; if (bif.valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b want=0", bif.valid); end
    checks++; if (bif.last !== 1'b0) begin failures++; $display("FAIL reset_last got=%b want=0", bif.last); end
    checks++; if (bif.busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b want=0", bif.busy); end
    checks++; if (bif.datar !== 16'h0000) begin failures++; $display("FAIL reset_datar got=%h want=0000", bif.datar); end
    checks++; if (bif.datai !== 16'h0000) begin failures++; $display("FAIL reset_datai got=%h want=0000", bif.datai); end
    bif.start = 1'b0;
    rst = 1'b0;
    step();
  endtask

  task automatic test_stage0();
    bif.ready = 1'b1;
    do_start(0);
    checks++; if (bif.busy !== 1'b1 || bif.valid !== 1'b0) begin failures++; $display("FAIL s0_cycle1 busy=%b valid=%b want busy=1 valid=0", bif.busy, bif.valid); end
    step();
    checks++; if (bif.valid !== 1'b0) begin failures++; $display("FAIL s0_cycle2_valid got=%b want=0", bif.valid); end
    step();
    checks++; if (bif.valid !== 1'b1) begin failures++; $display("FAIL s0_latency_valid got=%b want=1", bif.valid); end
    collect(100, 1024, 1500, -1, 0);
    checks++; if (timed_out) begin failures++; $display("FAIL s0_timeout got=%0d words want=1024", got_re.size()); end
    checks++; if (got_re.size() != 1024) begin failures++; $display("FAIL s0_count got=%0d want=1024", got_re.size()); end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (gre(i) != 32767 || gim(i) != 0) begin
        failures++; $display("FAIL s0_word%0d got=(%0d,%0d) want=(32767,0)", i, gre(i), gim(i));
      end
    end
    checks++; if (count_mismatch(0, 1'b0) != 0) begin failures++; $display("FAIL s0_model got=%0d mismatches want=0", count_mismatch(0, 1'b0)); end
    checks++; if (last_cyc - first_cyc != 1023) begin failures++; $display("FAIL s0_no_bubbles got=%0d cycles want=1023", last_cyc - first_cyc); end
    checks++; if (bif.busy !== 1'b0 || bif.valid !== 1'b0) begin failures++; $display("FAIL s0_end busy=%b valid=%b want 0 0", bif.busy, bif.valid); end
    ref_re = got_re;
    ref_im = got_im;
  endtask

  task automatic test_stage3();
    int wre[4] = '{32767, 23170, 0, -23170};
    int wim[4] = '{0, -23170, -32767, -23170};
    bif.ready = 1'b1;
    do_start(3);
    collect(100, 1024, 1500, -1, 0);
    checks++; if (got_re.size() != 1024) begin failures++; $display("FAIL s3_count got=%0d want=1024", got_re.size()); end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (gre(8 + i) != wre[i] || gim(8 + i) != wim[i]) begin
        failures++; $display("FAIL s3_b2_m%0d got=(%0d,%0d) want=(%0d,%0d)", i, gre(8 + i), gim(8 + i), wre[i], wim[i]);
      end
    end
    checks++; if (gre(5) != 30273 || gim(5) != -12539) begin failures++; $display("FAIL s3_k64 got=(%0d,%0d) want=(30273,-12539)", gre(5), gim(5)); end
    checks++; if (count_mismatch(3, 1'b0) != 0) begin failures++; $display("FAIL s3_model got=%0d mismatches want=0", count_mismatch(3, 1'b0)); end
  endtask

  task automatic test_random_ready();
    int diff, stg;
    do_start(0);
    collect(50, 1024, 8000, -1, 0);
    diff = 0;
    for (int i = 0; i < got_re.size() && i < ref_re.size(); i++)
      if (got_re[i] != ref_re[i] || got_im[i] != ref_im[i]) diff++;
    checks++; if (got_re.size() != 1024) begin failures++; $display("FAIL rr_count got=%0d want=1024", got_re.size()); end
    checks++; if (diff != 0) begin failures++; $display("FAIL rr_vs_ready1 got=%0d diffs want=0", diff); end
    checks++; if (hold_viol != 0) begin failures++; $display("FAIL rr_hold got=%0d violations want=0", hold_viol); end
    checks++; if (bif.busy !== 1'b0) begin failures++; $display("FAIL rr_busy_end got=%b want=0", bif.busy); end
    stg = int'($urandom_range(1, 4));
    do_start(stg);
    collect(70, 1024, 8000, -1, 0);
    checks++; if (got_re.size() != 1024) begin failures++; $display("FAIL rr2_count got=%0d want=1024", got_re.size()); end
    checks++; if (count_mismatch(stg, 1'b0) != 0) begin failures++; $display("FAIL rr2_model stage=%0d got=%0d mismatches want=0", stg, count_mismatch(stg, 1'b0)); end
    checks++; if (hold_viol != 0) begin failures++; $display("FAIL rr2_hold got=%0d violations want=0", hold_viol); end
  endtask

  task automatic test_mid_reset();
    do_start(0);
    collect(80, 500, 4000, -1, 0);
    checks++; if (got_re.size() != 500) begin failures++; $display("FAIL mr_prefix got=%0d want=500", got_re.size()); end
    rst = 1'b1;
    step();
    checks++; if (bif.valid !== 1'b0 || bif.last !== 1'b0 || bif.busy !== 1'b0) begin failures++; $display("FAIL mr_flags valid=%b last=%b busy=%b want 0 0 0", bif.valid, bif.last, bif.busy); end
    checks++; if (bif.datar !== 16'h0000 || bif.datai !== 16'h0000) begin failures++; $display("FAIL mr_data got=(%h,%h) want=(0000,0000)", bif.datar, bif.datai); end
    step();
    checks++; if (bif.valid !== 1'b0 || bif.busy !== 1'b0) begin failures++; $display("FAIL mr_hold valid=%b busy=%b want 0 0", bif.valid, bif.busy); end
    rst = 1'b0;
    bif.start = 1'b1;
    bif.stage = 3'd1;
    step();
    bif.start = 1'b0;
    checks++; if (bif.busy !== 1'b1) begin failures++; $display("FAIL mr_first_start busy got=%b want=1", bif.busy); end
    collect(100, 1024, 1500, -1, 0);
    checks++; if (got_re.size() != 1024) begin failures++; $display("FAIL mr_count got=%0d want=1024", got_re.size()); end
    checks++; if (gre(0) != 32767 || gim(0) != 0) begin failures++; $display("FAIL mr_first_word got=(%0d,%0d) want=(32767,0)", gre(0), gim(0)); end
    checks++; if (count_mismatch(1, 1'b0) != 0) begin failures++; $display("FAIL mr_model got=%0d mismatches want=0", count_mismatch(1, 1'b0)); end
  endtask

  task automatic test_ignored_starts();
    bif.ready = 1'b1;
    do_start(5);
    checks++; if (bif.busy !== 1'b0) begin failures++; $display("FAIL bad5_busy got=%b want=0", bif.busy); end
    repeat (3) step();
    checks++; if (bif.valid !== 1'b0 || bif.busy !== 1'b0) begin failures++; $display("FAIL bad5_idle valid=%b busy=%b want 0 0", bif.valid, bif.busy); end
    do_start(int'($urandom_range(5, 7)));
    checks++; if (bif.busy !== 1'b0) begin failures++; $display("FAIL badhi_busy got=%b want=0", bif.busy); end
    do_start(4);
    collect(100, 1024, 1500, 100, int'($urandom_range(0, 3)));
    checks++; if (got_re.size() != 1024) begin failures++; $display("FAIL busy_start_count got=%0d want=1024", got_re.size()); end
    checks++; if (count_mismatch(4, 1'b0) != 0) begin failures++; $display("FAIL busy_start_model got=%0d mismatches want=0", count_mismatch(4, 1'b0)); end
    step();
    checks++; if (bif.busy !== 1'b0 || bif.valid !== 1'b0) begin failures++; $display("FAIL busy_start_end busy=%b valid=%b want 0 0", bif.busy, bif.valid); end
  endtask

`ifdef TWIDDLE_GEN_CONJ_EN
  task automatic test_conj();
    bif.ready = 1'b1;
    inv = 1'b1;
    do_start(3);
    inv = 1'b0;
    collect(60, 1024, 8000, -1, 0);
    checks++; if (gre(9) != 23170 || gim(9) != 23170) begin failures++; $display("FAIL conj_k128 got=(%0d,%0d) want=(23170,23170)", gre(9), gim(9)); end
    checks++; if (gre(10) != 0 || gim(10) != 32767) begin failures++; $display("FAIL conj_k256 got=(%0d,%0d) want=(0,32767)", gre(10), gim(10)); end
    checks++; if (got_re.size() != 1024) begin failures++; $display("FAIL conj_count got=%0d want=1024", got_re.size()); end
    checks++; if (count_mismatch(3, 1'b1) != 0) begin failures++; $display("FAIL conj_model got=%0d mismatches want=0", count_mismatch(3, 1'b1)); end
  endtask
`endif

  initial begin
    test_reset();
    test_stage0();
    test_stage3();
    test_random_ready();
    test_mid_reset();
    test_ignored_starts();
`ifdef TWIDDLE_GEN_CONJ_EN
    test_conj();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
